// File: rtl/miner_core_compress.sv
// SHA-256 compression: 64 (ROUNDS) rounds over a..h, then adds the result into the saved chaining value.
// Latency: start edge to done pulse is 1 (LOAD) + ROUNDS + 1 (ADD) + 1 cycles (67 for ROUNDS=64) with w_valid held high.
// Backpressure: a low w_valid stalls the round (a..h and round hold); start is ignored while busy.
module miner_core_compress #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic [31:0]  w_word,
  input  logic         w_valid,
  output logic         busy,
  output logic [5:0]   round,
  output logic         done,
  output logic [255:0] h_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_ADD   = 2'd3;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  // FIPS 180-4 round constants, read combinationally by the current round index.
  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [1:0]   state;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [255:0] h_sav;

  logic [31:0] k_t;
  logic [31:0] big_s1, big_s0, ch, maj, t1, t2;

  assign busy = (state != ST_IDLE);
  assign k_t  = K_TAB[round];

  // One round of the compression function on the current working variables.
  always_comb begin
    big_s1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    ch     = (e & f) ^ (~e & g);
    big_s0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    maj    = (a & b) ^ (a & c) ^ (b & c);
    t1     = h + big_s1 + ch + k_t + w_word;
    t2     = big_s0 + maj;
  end

  // Sequencer and datapath: IDLE -> LOAD -> ROUND (stalls on !w_valid) -> ADD -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      d     <= '0;
      e     <= '0;
      f     <= '0;
      g     <= '0;
      h     <= '0;
      h_sav <= '0;
      round <= '0;
      h_out <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            h_sav <= h_in;
            a     <= h_in[255:224];
            b     <= h_in[223:192];
            c     <= h_in[191:160];
            d     <= h_in[159:128];
            e     <= h_in[127:96];
            f     <= h_in[95:64];
            g     <= h_in[63:32];
            h     <= h_in[31:0];
            round <= '0;
            state <= ST_LOAD;
          end
        end
        // Dead cycle so the schedule block can put W[0] on w_word.
        ST_LOAD: state <= ST_ROUND;
        ST_ROUND: begin
          if (w_valid) begin
            h     <= g;
            g     <= f;
            f     <= e;
            e     <= d + t1;
            d     <= c;
            c     <= b;
            b     <= a;
            a     <= t1 + t2;
            round <= round + 6'd1;
            if (round == LAST_ROUND) begin
              state <= ST_ADD;
            end
          end
        end
        ST_ADD: begin
          h_out <= {h_sav[255:224] + a, h_sav[223:192] + b,
                    h_sav[191:160] + c, h_sav[159:128] + d,
                    h_sav[127:96]  + e, h_sav[95:64]   + f,
                    h_sav[63:32]   + g, h_sav[31:0]    + h};
          done  <= 1'b1;
          round <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miner_core_compress.sv
// Randomised and directed bench for the SHA-256 compression stage with a scoreboard.
// Expected digests come from a behavioural SHA-256 model; a monitor pops them on each done pulse.
// Stimulus drives on the falling edge; checks sample on the falling edge.
module tb_miner_core_compress;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] h_in;
  logic [31:0]  w_word;
  logic         w_valid;
  logic         busy;
  logic [5:0]   round;
  logic         done;
  logic [255:0] h_out;

  miner_core_compress #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .h_in(h_in), .w_word(w_word),
    .w_valid(w_valid), .busy(busy), .round(round), .done(done), .h_out(h_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [255:0] dig;
    int           cyc;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'b0, 32'h00000018};
  localparam logic [511:0] PAD_BLK = {32'h80000000, 416'b0, 64'd512};

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural SHA-256 reference ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] blk);
    logic [31:0]   w [64];
    logic [2047:0] r;
    logic [31:0]   s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int t = 0; t < 64; t++) r[t*32 +: 32] = w[t];
    return r;
  endfunction

  // Working variables {a..h} after k rounds starting from chaining value hv.
  function automatic logic [255:0] run_rounds(input logic [255:0] hv, input logic [2047:0] wp, input int k);
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
    for (int t = 0; t < k; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wp[t*32 +: 32];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i];
    return r;
  endfunction

  function automatic logic [255:0] digest(input logic [255:0] hv, input logic [2047:0] wp);
    logic [255:0] st, r;
    st = run_rounds(hv, wp, 64);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = hv[32*i +: 32] + st[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t ex;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 256'(done), 256'(0));
      end else begin
        ex = exp_q.pop_front();
        check("h_out", h_out, ex.dig);
        check("done_latency", 256'(cyc), 256'(ex.cyc));
        check("busy_at_done", 256'(busy), 256'(0));
      end
    end
  end

  // ---------------- driver ----------------
  // Leaves the bench on the ADD-cycle falling edge, so the next call starts in the done cycle.
  task automatic run_block(input logic [255:0] hv, input logic [2047:0] wp, input logic [255:0] dig,
                           input int g1t, input int g1n, input int g2t, input int g2n,
                           input int inj_t, input int abort_t, input bit chk_first);
    exp_t         ex;
    logic [255:0] st;
    int           n;
    @(negedge clk);
    start = 1'b1; h_in = hv; w_valid = 1'b0;
    if (abort_t < 0) begin
      ex.dig = dig;
      ex.cyc = cyc + 67 + g1n + g2n;
      exp_q.push_back(ex);
    end
    @(negedge clk);
    start = 1'b0; h_in = rand256();
    check("busy_load", 256'(busy), 256'(1));
    check("round_load", 256'(round), 256'(0));
    for (int t = 0; t < 64; t++) begin
      n = (t == g1t) ? g1n : ((t == g2t) ? g2n : 0);
      for (int j = 0; j < n; j++) begin
        @(negedge clk);
        w_valid = 1'b0; start = 1'b0;
        st = run_rounds(hv, wp, t);
        check("stall_round", 256'(round), 256'(t));
        check("stall_a", 256'(dut.a), 256'(st[255:224]));
        check("stall_e", 256'(dut.e), 256'(st[127:96]));
      end
      @(negedge clk);
      start = (t == inj_t);
      if (start) h_in = rand256();
      if (t == abort_t) begin
        rst = 1'b1; w_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_round", 256'(round), 256'(0));
        check("abort_h_out", h_out, 256'(0));
        rst = 1'b0;
        return;
      end
      check("round_idx", 256'(round), 256'(t));
      if (chk_first && t == 1) begin
        check("first_a", 256'(dut.a), 256'(32'h5d6aebcd));
        check("first_e", 256'(dut.e), 256'(32'hfa2a4622));
      end
      w_valid = 1'b1;
      w_word  = wp[t*32 +: 32];
    end
    @(negedge clk);
    w_valid = 1'b0; start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [2047:0] w_abc, w1, w2;
    logic [511:0]  blk;
    logic [255:0]  hv, d1, d2;

    w_abc = expand(ABC_BLK);

    // Reset with start held high.
    rst = 1'b1; start = 1'b1; h_in = rand256(); w_valid = 1'b1; w_word = $urandom;
    repeat (2) @(negedge clk);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_h_out", h_out, 256'(0));
    check("rst_round", 256'(round), 256'(0));
    rst = 1'b0; start = 1'b0; w_valid = 1'b0;
    idle(2);

    // "abc" block, no stalls.
    run_block(H0, w_abc, ABC_DIG, -1, 0, -1, 0, -1, -1, 1);
    idle(3);
    // Stalls at rounds 10 and 63.
    run_block(H0, w_abc, ABC_DIG, 10, 5, 63, 3, -1, -1, 0);
    idle(3);
    // start pulsed mid-run with a different h_in.
    run_block(H0, w_abc, ABC_DIG, -1, 0, -1, 0, 30, -1, 0);
    idle(3);
    // Reset at round 40, then a clean run.
    run_block(H0, w_abc, 256'(0), -1, 0, -1, 0, -1, 40, 0);
    idle(2);
    run_block(H0, w_abc, ABC_DIG, -1, 0, -1, 0, -1, -1, 0);
    idle(3);

    // Two-block message, second block started in the done cycle of the first.
    blk = rand512();
    w1  = expand(blk);
    d1  = digest(H0, w1);
    w2  = expand(PAD_BLK);
    d2  = digest(d1, w2);
    run_block(H0, w1, d1, -1, 0, -1, 0, -1, -1, 0);
    run_block(d1, w2, d2, -1, 0, -1, 0, -1, -1, 0);
    idle(3);

    // Random chaining values, blocks and stall placement.
    for (int k = 0; k < 3; k++) begin
      hv  = rand256();
      blk = rand512();
      w1  = expand(blk);
      run_block(hv, w1, digest(hv, w1),
                int'($urandom_range(1, 30)), int'($urandom_range(1, 4)),
                int'($urandom_range(31, 63)), int'($urandom_range(1, 4)), -1, -1, 0);
      idle(int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) check("done_timeout", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/miner_core_compress.md
Name: miner_core_compress

Overview:
SHA-256 compression stage. Consumes the message-schedule words W[0..63] produced by the upstream message-schedule block, one word per cycle. Runs 64 rounds over working variables a..h, then adds the result into the chaining value to produce the 256-bit intermediate or final digest. Sits downstream of the message-schedule block and is sequenced by the core control unit through start/w_valid/done.

Parameters:
ROUNDS, 64, number of compression rounds. The legal range is 1..64; values below 64 are for debug and bring-up only.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a compression; sampled only in IDLE
h_in  input  256  chaining value H0..H7; H0 = h_in[255:224], H7 = h_in[31:0]
w_word  input  32  message-schedule word W[t] for the current round
w_valid  input  1  w_word is valid this cycle; the round advances only when high
busy  output  1  high in LOAD, ROUND and ADD
round  output  6  index t of the word expected next (0..ROUNDS-1)
done  output  1  one-cycle pulse when h_out is valid
h_out  output  256  resulting hash, same word ordering as h_in; held until the next done

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; a..h, saved H, round, h_out all 0; busy=0; done=0. Reset wins over every other input, including mid-compression; a partial compression is discarded.
- States: IDLE, LOAD, ROUND, ADD.
- IDLE:
  - start=1 -> latch h_in into the saved-H registers and into a..h; round=0; go to LOAD.
  - start=0 -> stay in IDLE.
  - w_valid is ignored in IDLE.
- LOAD: single cycle, no arithmetic; always go to ROUND. This gives the upstream stage one cycle to present W[0].
- ROUND:
  - If w_valid=1, perform one round with K[round] and w_word:
    - T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t]
    - T2 = S0(a) + Maj(a,b,c)
    - S1 = ROTR6^ROTR11^ROTR25
    - S0 = ROTR2^ROTR13^ROTR22
    - h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2
    - All additions are modulo 2^32; carries are discarded.
    - round increments.
  - If w_valid=0 -> stall: a..h and round hold.
  - If w_valid=1 and round=ROUNDS-1 -> perform the final round, then go to ADD.
- ADD: single cycle.
  - h_out word i = saved H word i + working variable i (mod 2^32).
  - Next state IDLE; done=1 in the cycle following ADD, for exactly one cycle.
- K[0..63] is the standard FIPS 180-4 constant table, held as a combinational ROM indexed by round.
- start while busy=1 is ignored and has no effect on the compression in progress.
- start in the same cycle that done=1 (state IDLE) is accepted, giving back-to-back compressions.
- h_in is sampled only on the start edge; later changes to h_in do not affect the result.
- Latency with w_valid held high: start edge -> done = 1 (LOAD) + ROUNDS + 1 (ADD) + 1 cycles; 67 cycles for ROUNDS=64.
- busy rises the cycle after start is accepted and falls in the same cycle done rises.
- round stays at 0 in IDLE and LOAD, and is reset to 0 on leaving ADD.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 -> busy=0, done=0, h_out=0, round=0.
- "abc" block: h_in=6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; W from a reference model (W0=61626380, W1..W14=0, W15=00000018); w_valid held high.
  - After the first round: a=5d6aebcd, e=fa2a4622.
  - done 67 cycles after start; h_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Stall: same "abc" vector with w_valid dropped for 5 cycles at round 10 and 3 cycles at round 63 -> round and a..h frozen during gaps; identical h_out; done at cycle 75.
- Start while busy: pulse start with a different h_in at round 30 -> ignored; "abc" digest unchanged.
- Mid-run reset: rst at round 40, then a new "abc" start -> clean correct digest with no residue from the aborted run.
- Back-to-back: start in the done cycle with h_in = previous h_out and a padding-block W stream -> second done 67 cycles later, matching the two-block model digest.
